// File: rtl/zbb_count_seq.sv
// zbb_count_seq: sequencer around one shared 32-bit count-trailing-zeros encoder.
//   CTZ  - operand goes straight to the encoder.
//   CLZ  - operand is bit-reversed on accept, then goes to the encoder.
//   CPOP - iterative clear-lowest-set-bit loop that counts iterations, or a
//          single-cycle adder tree when ZBB_CPOP_FAST_EN is defined.
// Only one op is in flight at a time, with valid/ready handshakes on both sides.
module zbb_count_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_CTZ  = 2'b00;
    localparam logic [1:0] OP_CLZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   x_q, x_d;
    logic [1:0]              op_q, op_d;
    logic [CNT_W-1:0]        res_q, res_d;
    logic [DATA_WIDTH-1:0]   rs1_rev;
    logic [CNT_W-1:0]        ctz_enc;
`ifdef ZBB_CPOP_FAST_EN
    logic [CNT_W-1:0]        pop_sum;
`else
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    // Bit-reverse the incoming operand so CLZ can reuse the trailing-zero encoder
    always_comb begin
        rs1_rev = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            rs1_rev[i] = rs1[DATA_WIDTH-1-i];
        end
    end

    // Trailing-zero encoder; scanning from the MSB lets the lowest set bit win, zero input yields DATA_WIDTH
    always_comb begin
        ctz_enc = CNT_W'(DATA_WIDTH);
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (x_q[DATA_WIDTH-1-i]) begin
                ctz_enc = CNT_W'(DATA_WIDTH - 1 - i);
            end
        end
    end

`ifdef ZBB_CPOP_FAST_EN
    // Single-cycle population count over the latched operand
    always_comb begin
        pop_sum = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            pop_sum = pop_sum + CNT_W'(x_q[i]);
        end
    end
`endif

    // State and datapath registers; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
`ifndef ZBB_CPOP_FAST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            op_q    <= op_d;
            res_q   <= res_d;
`ifndef ZBB_CPOP_FAST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = CALC;
`ifdef ZBB_CPOP_FAST_EN
            CALC: state_d = DONE;
`else
            CALC: if (op_q != OP_CPOP || x_q == '0) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: operand/op capture on accept, result write in CALC
    always_comb begin
        x_d   = x_q;
        op_d  = op_q;
        res_d = res_q;
`ifndef ZBB_CPOP_FAST_EN
        cnt_d = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    x_d  = (op == OP_CLZ) ? rs1_rev : rs1;
`ifndef ZBB_CPOP_FAST_EN
                    cnt_d = '0;
`endif
                end
            end
            CALC: begin
                case (op_q)
                    OP_CTZ, OP_CLZ: res_d = ctz_enc;
`ifdef ZBB_CPOP_FAST_EN
                    OP_CPOP: res_d = pop_sum;
`else
                    OP_CPOP: begin
                        if (x_q == '0) begin
                            res_d = cnt_q;
                        end else begin
                            x_d   = x_q & (x_q - 1'b1);
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`endif
                    default: res_d = '0;
                endcase
            end
            default: ;
        endcase
    end

    // Output decode from state and the held result
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = {{(DATA_WIDTH-CNT_W){1'b0}}, res_q};
    end

endmodule

// File: tb/tb_zbb_count_seq.sv
module tb_zbb_count_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

`ifdef ZBB_CPOP_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    zbb_count_seq #(.DATA_WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] exp_res;
        int          exp_lat;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the op definitions
    function automatic int ref_ctz(input logic [31:0] a);
        for (int i = 0; i < 32; i++) if (a[i]) return i;
        return 32;
    endfunction

    function automatic int ref_clz(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[31-n]) n++;
        return n;
    endfunction

    function automatic int ref_pop(input logic [31:0] a);
        int n = 0;
        for (int i = 0; i < 32; i++) n += a[i];
        return n;
    endfunction

    function automatic int ref_res(input logic [1:0] o, input logic [31:0] a);
        case (o)
            2'b00:   return ref_ctz(a);
            2'b01:   return ref_clz(a);
            2'b10:   return ref_pop(a);
            default: return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a);
        if (o == 2'b10 && !FAST) return 2 + ref_pop(a);
        return 2;
    endfunction

    // Issue one op starting at a negedge; ends at the negedge after the output handshake
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] exp_res, input int exp_lat, input int hold,
                          input bit check_wait);
        int waited = 0;
        int e = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (check_wait) chk({name, " accept_wait"}, 64'(waited), 64'd0);
        if (!in_ready) begin
            chk({name, " in_ready_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1; op = o; rs1 = a; out_ready = 1'b0;
        do begin
            @(negedge clk);
            e++;
            if (e == 1) begin
                in_valid = 1'b0; op = 2'($urandom); rs1 = $urandom;
            end
        end while (!out_valid && e < 100);
        chk({name, " latency"}, 64'(e), 64'(exp_lat));
        chk({name, " result"}, 64'(result), 64'(exp_res));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; op = 2'($urandom); rs1 = $urandom;
            @(negedge clk);
            chk({name, " hold {ov,ir,busy,res}"}, {29'd0, out_valid, in_ready, busy, result},
                {29'd0, 1'b1, 1'b0, 1'b1, exp_res});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " post {ir,ov,busy}"}, {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
    endtask

    vec_t tbl[$];

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; rs1 = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset {ir,ov,busy,res}", {29'd0, in_ready, out_valid, busy, result}, {29'd0, 3'b100, 32'd0});
        rst = 1'b0;

        tbl.push_back('{2'b00, 32'h0000_0100, 32'd8,  2, 0});
        tbl.push_back('{2'b00, 32'h0000_0000, 32'd32, 2, 0});
        tbl.push_back('{2'b00, 32'h8000_0000, 32'd31, 2, 1});
        tbl.push_back('{2'b01, 32'h0001_0000, 32'd15, 2, 0});
        tbl.push_back('{2'b01, 32'h0000_0000, 32'd32, 2, 0});
        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'd0,  2, 2});
        tbl.push_back('{2'b10, 32'h0000_00F0, 32'd4,  FAST ? 2 : 6, 0});
        tbl.push_back('{2'b10, 32'h0000_0000, 32'd0,  2, 0});
        tbl.push_back('{2'b10, 32'hFFFF_FFFF, 32'd32, FAST ? 2 : 34, 0});
        tbl.push_back('{2'b00, 32'h0000_0004, 32'd2,  2, 10});
        tbl.push_back('{2'b11, 32'h0000_1234, 32'd0,  2, 0});
        tbl.push_back('{2'b00, 32'h0000_0010, 32'd4,  2, 0});

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs1, tbl[i].exp_res,
                   tbl[i].exp_lat, tbl[i].hold, 1'b1);
        end

        // Reset in the middle of a long CPOP: nothing may come out afterwards
        in_valid = 1'b1; op = 2'b10; rs1 = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_reset {ir,ov,busy,res}", {29'd0, in_ready, out_valid, busy, result}, {29'd0, 3'b100, 32'd0});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("midop_reset no_result", 64'(seen), 64'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = '0;
                1:       ra = '1;
                2:       ra = 32'd1 << $urandom_range(0, 31);
                3:       ra = $urandom & $urandom & $urandom;
                default: ra = $urandom;
            endcase
            run_op($sformatf("rand%0d op=%0d rs1=%08h", n, ro, ra), ro, ra,
                   32'(ref_res(ro, ra)), ref_lat(ro, ra), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
